enemy_director: RTL and testbench
=================================

ENEMY_DIRECTOR -- requirements
Module: enemy_director

Interface
REQ-001 Parameters SHALL be: NUM_SLOTS, default 4, number of enemy slots driven.
REQ-002 TICK_DIV, default 16, SHALL set clocks per battle round (legal values >= 8).
REQ-003 SPAWN_COOLDOWN, default 3, SHALL set rounds between spawn attempts.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enable  in  1  permits a new round to start.
REQ-007 playerFront  in  9  position of the frontmost player unit.
REQ-008 playerDamage  in  8  damage player units deal this round.
REQ-009 enemyPos  in  9*NUM_SLOTS  per-slot enemy position, slot i at bits [9i+8:9i].
REQ-010 enemyDamage  in  8*NUM_SLOTS  per-slot enemy damageOut.
REQ-011 enemyDead  in  NUM_SLOTS  per-slot dead flag.
REQ-012 moveSCEN  out  1  one-cycle move strobe to all slots.
REQ-013 damageSCEN  out  1  one-cycle damage strobe to all slots.
REQ-014 unitFront  out  9  registered copy of playerFront, broadcast to all slots.
REQ-015 damageToEnemy  out  8*NUM_SLOTS  per-slot damageIn.
REQ-016 canSpawn  out  NUM_SLOTS  one-hot spawn strobe.
REQ-017 spawnType  out  2  spawn kind, valid with canSpawn.
REQ-018 enemyFront  out  9  largest position among live enemies, 0 if none.
REQ-019 baseDamage  out  8  saturated enemy damage total, held for one round.
REQ-020 roundCount  out  16  completed rounds, wraps at 16'hFFFF -> 0.

Function
REQ-021 FSM states SHALL be WAIT, MOVE, COLLECT, DAMAGE, SPAWN; each non-WAIT state SHALL last exactly one cycle.
REQ-022 In WAIT, tick counter SHALL increment while enable=1 and hold while enable=0; at TICK_DIV-1 it SHALL clear and the FSM SHALL go to MOVE.
REQ-023 MOVE: moveSCEN=1 for that cycle only; unitFront SHALL be loaded from playerFront in the same cycle.
REQ-024 COLLECT: baseDamage SHALL load the sum of enemyDamage over slots with enemyDead=0, saturating at 255.
REQ-025 COLLECT: the front index SHALL be latched as the live slot with the largest enemyPos, ties to the lowest index; enemyFront SHALL load that position, or 0 if no slot is live.
REQ-026 DAMAGE: damageSCEN=1 and damageToEnemy[front]=playerDamage for that cycle only; with no live slot, damage SHALL be discarded.
REQ-027 damageToEnemy SHALL be all-zero in every state other than DAMAGE, because slots compare damageIn continuously.
REQ-028 SPAWN: when cooldown=0 and at least one enemyDead bit is set, canSpawn SHALL pulse one cycle on the lowest-index dead slot; cooldown SHALL then reload SPAWN_COOLDOWN.
REQ-029 SPAWN: otherwise canSpawn SHALL stay 0 and a nonzero cooldown SHALL decrement by 1.
REQ-030 spawnType SHALL equal lfsr[1:0], sampled in SPAWN.
REQ-031 SPAWN SHALL increment roundCount and return to WAIT.
REQ-032 The LFSR SHALL be 8 bits, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, advanced every cycle; it SHALL never hold 0.
REQ-033 enable falling mid-round SHALL NOT abort the round; the remaining states complete and the FSM then holds in WAIT.
REQ-034 At most one canSpawn bit SHALL be high per round; no spawn SHALL occur in DAMAGE or MOVE.

Reset
REQ-035 reset SHALL immediately force WAIT; tick, cooldown and roundCount to 0; lfsr to 8'hA5.
REQ-036 reset SHALL immediately force all outputs to 0, including mid-round.
REQ-037 The first round after reset SHALL be allowed to spawn, since cooldown is 0.

Structure
REQ-038 Package battle_pkg SHALL hold FSM state encodings, POS_W=9, DMG_W=8, the LFSR seed and taps, and the default NUM_SLOTS.
REQ-039 The LFSR SHALL be the sub-module lfsr8 (clk, reset, out[7:0]); front selection and the saturating sum SHALL stay inline.

Verification
REQ-040 All slots dead, enable=1 -> at cycle 19 after reset release, canSpawn=4'b0001 for one cycle; the next spawn occurs 4 rounds later.
REQ-041 Slots 0-2 live at positions 10/30/30, playerDamage=7 -> enemyFront=30 and damageToEnemy slot1=7 only during damageSCEN; 0 in every other cycle.
REQ-042 Four live slots with enemyDamage=200 each -> baseDamage=255.
REQ-043 Live slots with enemyDamage=5 and 6, a dead slot with 100 -> baseDamage=11.
REQ-044 No live slots, playerDamage=50 -> damageSCEN pulses and damageToEnemy stays all-zero; enemyFront=0.
REQ-045 Assert reset in DAMAGE -> same cycle: damageSCEN=0, damageToEnemy=0, roundCount=0; after release, first moveSCEN arrives after 16 enabled cycles.

Source files
------------

// File: rtl/battle_pkg.sv
// battle_pkg
//   Shared definitions for the battle round director and its helpers:
//   director FSM state encoding, position/damage field widths, the spawn
//   LFSR seed and feedback taps, and the default number of enemy slots.
//   No ports (package).

package battle_pkg;

  localparam int POS_W             = 9;
  localparam int DMG_W             = 8;
  localparam int DEFAULT_NUM_SLOTS = 4;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci
  // register: bits 7, 5, 4 and 3 are XORed into bit 0.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    WAIT    = 3'd0,
    MOVE    = 3'd1,
    COLLECT = 3'd2,
    DAMAGE  = 3'd3,
    SPAWN   = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr8.sv
// lfsr8
//   Free-running 8-bit maximal-length LFSR that supplies pseudo-random spawn
//   kinds. Advances on every clock edge.
//   Ports:
//     clk   - system clock
//     reset - asynchronous active-high reset, loads the seed
//     out   - current register value, never zero

module lfsr8
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] out
);

  logic [7:0] r_state;
  logic       w_feedback;
  logic [7:0] w_next;

  assign w_feedback = ^(r_state & LFSR_TAPS);
  assign w_next     = {r_state[6:0], w_feedback};

  // Shift every cycle; the all-zero lock-up state is unreachable from the
  // seed, but it is steered back to the seed anyway so the register can
  // never get stuck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LFSR_SEED;
    end else if (w_next == 8'h00) begin
      r_state <= LFSR_SEED;
    end else begin
      r_state <= w_next;
    end
  end

  assign out = r_state;

endmodule

// File: rtl/enemy_director.sv
// enemy_director
//   Paces the battle in fixed-length rounds. Each round waits TICK_DIV
//   enabled clocks, then steps MOVE -> COLLECT -> DAMAGE -> SPAWN, one cycle
//   each, strobing the enemy slots, collecting their damage into a
//   saturated base-damage total, aiming player damage at the frontmost live
//   enemy and periodically spawning into the lowest-index dead slot.
//   Ports:
//     clk, reset     - clock and asynchronous active-high reset
//     enable         - allows a new round to start
//     playerFront    - frontmost player position, copied to unitFront in MOVE
//     playerDamage   - player damage delivered to the front enemy in DAMAGE
//     enemyPos       - packed per-slot enemy positions (9 bits per slot)
//     enemyDamage    - packed per-slot enemy damage outputs (8 bits per slot)
//     enemyDead      - per-slot dead flags
//     moveSCEN       - one-cycle move strobe (MOVE)
//     damageSCEN     - one-cycle damage strobe (DAMAGE)
//     unitFront      - registered player front
//     damageToEnemy  - packed per-slot damage, nonzero only in DAMAGE
//     canSpawn       - one-hot spawn strobe (SPAWN)
//     spawnType      - spawn kind, valid with canSpawn
//     enemyFront     - position of the frontmost live enemy, 0 if none
//     baseDamage     - saturated live-enemy damage total for the round
//     roundCount     - completed rounds, wrapping

module enemy_director
  import battle_pkg::*;
#(
  parameter int NUM_SLOTS      = DEFAULT_NUM_SLOTS,
  parameter int TICK_DIV       = 16,
  parameter int SPAWN_COOLDOWN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [POS_W-1:0]           playerFront,
  input  logic [DMG_W-1:0]           playerDamage,
  input  logic [POS_W*NUM_SLOTS-1:0] enemyPos,
  input  logic [DMG_W*NUM_SLOTS-1:0] enemyDamage,
  input  logic [NUM_SLOTS-1:0]       enemyDead,
  output logic                       moveSCEN,
  output logic                       damageSCEN,
  output logic [POS_W-1:0]           unitFront,
  output logic [DMG_W*NUM_SLOTS-1:0] damageToEnemy,
  output logic [NUM_SLOTS-1:0]       canSpawn,
  output logic [1:0]                 spawnType,
  output logic [POS_W-1:0]           enemyFront,
  output logic [DMG_W-1:0]           baseDamage,
  output logic [15:0]                roundCount
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W   = (SPAWN_COOLDOWN > 0) ? $clog2(SPAWN_COOLDOWN + 1) : 1;
  localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SUM_W  = DMG_W + $clog2(NUM_SLOTS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]   CD_RELOAD = CD_W'(SPAWN_COOLDOWN);
  localparam logic [SUM_W-1:0]  DMG_MAX   = SUM_W'((1 << DMG_W) - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [TICK_W-1:0]    r_tick;
  logic [CD_W-1:0]      r_cooldown;
  logic [15:0]          r_roundCount;
  logic [POS_W-1:0]     r_unitFront;
  logic [POS_W-1:0]     r_enemyFront;
  logic [DMG_W-1:0]     r_baseDamage;
  logic [IDX_W-1:0]     r_frontIdx;
  logic                 r_frontValid;

  logic [IDX_W-1:0]     w_frontIdx;
  logic                 w_frontValid;
  logic [POS_W-1:0]     w_frontPos;
  logic [SUM_W-1:0]     w_damageSum;
  logic [NUM_SLOTS-1:0] w_lowestDead;
  logic                 w_spawnNow;
  logic [7:0]           w_lfsr;
  logic [5:0]           w_unusedLfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (w_lfsr)
  );

  assign w_unusedLfsr = w_lfsr[7:2];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: only WAIT looks at enable, so a round that has started
  // always runs to completion.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      WAIT:    if (enable && (r_tick == TICK_LAST)) w_nextState = MOVE;
      MOVE:    w_nextState = COLLECT;
      COLLECT: w_nextState = DAMAGE;
      DAMAGE:  w_nextState = SPAWN;
      SPAWN:   w_nextState = WAIT;
      default: w_nextState = WAIT;
    endcase
  end

  // Round pacing counter, frozen while enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick <= '0;
    end else if ((r_state == WAIT) && enable) begin
      r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TICK_W'(1);
    end
  end

  // Frontmost live enemy; strict compare keeps the lowest index on ties.
  always_comb begin
    w_frontValid = 1'b0;
    w_frontIdx   = '0;
    w_frontPos   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!enemyDead[i] &&
          (!w_frontValid || (enemyPos[i*POS_W +: POS_W] > w_frontPos))) begin
        w_frontValid = 1'b1;
        w_frontIdx   = IDX_W'(i);
        w_frontPos   = enemyPos[i*POS_W +: POS_W];
      end
    end
  end

  // Live-enemy damage total, wide enough never to overflow before saturation.
  always_comb begin
    w_damageSum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!enemyDead[i]) begin
        w_damageSum = w_damageSum + SUM_W'(enemyDamage[i*DMG_W +: DMG_W]);
      end
    end
  end

  // Player front is captured in MOVE; enemy front and base damage in COLLECT,
  // so DAMAGE aims at a target that cannot shift under it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_unitFront  <= '0;
      r_enemyFront <= '0;
      r_baseDamage <= '0;
      r_frontIdx   <= '0;
      r_frontValid <= 1'b0;
    end else begin
      if (r_state == MOVE) begin
        r_unitFront <= playerFront;
      end
      if (r_state == COLLECT) begin
        r_enemyFront <= w_frontPos;
        r_baseDamage <= (w_damageSum > DMG_MAX) ? {DMG_W{1'b1}} : w_damageSum[DMG_W-1:0];
        r_frontIdx   <= w_frontIdx;
        r_frontValid <= w_frontValid;
      end
    end
  end

  // Lowest set dead bit, isolated with the two's-complement trick.
  assign w_lowestDead = enemyDead & (~enemyDead + NUM_SLOTS'(1));
  assign w_spawnNow   = (r_state == SPAWN) && (r_cooldown == '0) && (|enemyDead);

  // Spawn cooldown and round counter both advance once per round in SPAWN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cooldown   <= '0;
      r_roundCount <= '0;
    end else if (r_state == SPAWN) begin
      if (w_spawnNow) begin
        r_cooldown <= CD_RELOAD;
      end else if (r_cooldown != '0) begin
        r_cooldown <= r_cooldown - CD_W'(1);
      end
      r_roundCount <= r_roundCount + 16'd1;
    end
  end

  // Strobes are decoded from the state alone, so reset clears them at once.
  always_comb begin
    moveSCEN      = 1'b0;
    damageSCEN    = 1'b0;
    damageToEnemy = '0;
    canSpawn      = '0;
    spawnType     = 2'b00;
    case (r_state)
      MOVE: moveSCEN = 1'b1;
      DAMAGE: begin
        damageSCEN = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (r_frontValid && (r_frontIdx == IDX_W'(i))) begin
            damageToEnemy[i*DMG_W +: DMG_W] = playerDamage;
          end
        end
      end
      SPAWN: begin
        if (w_spawnNow) begin
          canSpawn  = w_lowestDead;
          spawnType = w_lfsr[1:0];
        end
      end
      default: ;
    endcase
  end

  assign unitFront  = r_unitFront;
  assign enemyFront = r_enemyFront;
  assign baseDamage = r_baseDamage;
  assign roundCount = r_roundCount;

endmodule

// File: tb/tb_enemy_director.sv
// tb_enemy_director
//   Self-checking bench for enemy_director with default parameters.
//   Table-driven rounds feed a scoreboard queue that is drained on each
//   damage strobe; hand-written sequences cover spawn timing and cooldown,
//   enable dropping mid-round, and reset asserted during DAMAGE.

module tb_enemy_director;
  import battle_pkg::*;

  localparam int NS = 4;

  logic                clk;
  logic                reset;
  logic                enable;
  logic [POS_W-1:0]    playerFront;
  logic [DMG_W-1:0]    playerDamage;
  logic [POS_W*NS-1:0] enemyPos;
  logic [DMG_W*NS-1:0] enemyDamage;
  logic [NS-1:0]       enemyDead;
  logic                moveSCEN;
  logic                damageSCEN;
  logic [POS_W-1:0]    unitFront;
  logic [DMG_W*NS-1:0] damageToEnemy;
  logic [NS-1:0]       canSpawn;
  logic [1:0]          spawnType;
  logic [POS_W-1:0]    enemyFront;
  logic [DMG_W-1:0]    baseDamage;
  logic [15:0]         roundCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [POS_W*NS-1:0] pos;
    logic [DMG_W*NS-1:0] dmg;
    logic [NS-1:0]       dead;
    logic [POS_W-1:0]    pFront;
    logic [DMG_W-1:0]    pDmg;
    logic [POS_W-1:0]    expFront;
    logic [DMG_W-1:0]    expBase;
    logic [DMG_W*NS-1:0] expHit;
  } vec_t;

  typedef struct {
    logic [POS_W-1:0]    front;
    logic [DMG_W-1:0]    base;
    logic [DMG_W*NS-1:0] hit;
    logic [POS_W-1:0]    unit;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  enemy_director #(
    .NUM_SLOTS      (NS),
    .TICK_DIV       (16),
    .SPAWN_COOLDOWN (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .playerFront   (playerFront),
    .playerDamage  (playerDamage),
    .enemyPos      (enemyPos),
    .enemyDamage   (enemyDamage),
    .enemyDead     (enemyDead),
    .moveSCEN      (moveSCEN),
    .damageSCEN    (damageSCEN),
    .unitFront     (unitFront),
    .damageToEnemy (damageToEnemy),
    .canSpawn      (canSpawn),
    .spawnType     (spawnType),
    .enemyFront    (enemyFront),
    .baseDamage    (baseDamage),
    .roundCount    (roundCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream wedges the main sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test by 100000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    lfsrStep = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one round's inputs and queue what the round must produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    enemyPos     = v.pos;
    enemyDamage  = v.dmg;
    enemyDead    = v.dead;
    playerFront  = v.pFront;
    playerDamage = v.pDmg;
    e.front = v.expFront;
    e.base  = v.expBase;
    e.hit   = v.expHit;
    e.unit  = v.pFront;
    sb.push_back(e);
  endtask

  task automatic waitForDamage(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (damageSCEN) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL damageTimeout: got no damageSCEN in 60 cycles, expected one");
    end
  endtask

  // Called while the DUT is in DAMAGE: pop the oldest queued round and compare.
  task automatic checkRound(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_queue: got empty scoreboard, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_hit"},   64'(damageToEnemy), 64'(e.hit));
      checkOutput({tag, "_front"}, 64'(enemyFront),    64'(e.front));
      checkOutput({tag, "_base"},  64'(baseDamage),    64'(e.base));
      checkOutput({tag, "_unit"},  64'(unitFront),     64'(e.unit));
    end
  endtask

  // Continuous rules: damage only under its strobe, never two spawns at once.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (!damageSCEN && (damageToEnemy != '0)) begin
        errors++;
        $display("[TB] FAIL damageIdle: got 0x%0h without damageSCEN, expected 0", damageToEnemy);
      end
      checks++;
      if ($countones(canSpawn) > 1) begin
        errors++;
        $display("[TB] FAIL spawnOneHot: got 0x%0h, expected at most one bit", canSpawn);
      end
    end
  end

  initial begin
    logic [7:0] lfsrModel;
    bit         found;
    int         moveSeen;
    int         n;

    reset        = 1'b1;
    enable       = 1'b0;
    playerFront  = '0;
    playerDamage = '0;
    enemyPos     = '0;
    enemyDamage  = '0;
    enemyDead    = '0;

    vecs[0] = '{pos: {9'd500, 9'd30, 9'd30, 9'd10}, dmg: {8'd100, 8'd3, 8'd2, 8'd1},
                dead: 4'b1000, pFront: 9'd100, pDmg: 8'd7,
                expFront: 9'd30, expBase: 8'd6, expHit: 32'h0000_0700};
    vecs[1] = '{pos: {9'd40, 9'd300, 9'd20, 9'd511}, dmg: {4{8'd200}},
                dead: 4'b0000, pFront: 9'd12, pDmg: 8'd9,
                expFront: 9'd511, expBase: 8'd255, expHit: 32'h0000_0009};
    vecs[2] = '{pos: {9'd200, 9'd400, 9'd150, 9'd200}, dmg: {8'd0, 8'd100, 8'd6, 8'd5},
                dead: 4'b0100, pFront: 9'd300, pDmg: 8'h21,
                expFront: 9'd200, expBase: 8'd11, expHit: 32'h0000_0021};
    vecs[3] = '{pos: {9'd1, 9'd2, 9'd3, 9'd4}, dmg: {4{8'd99}},
                dead: 4'b1111, pFront: 9'd7, pDmg: 8'd50,
                expFront: 9'd0, expBase: 8'd0, expHit: 32'h0000_0000};
    vecs[4] = '{pos: {9'd256, 9'd500, 9'd500, 9'd500}, dmg: {4{8'd255}},
                dead: 4'b0111, pFront: 9'd511, pDmg: 8'hAB,
                expFront: 9'd256, expBase: 8'd255, expHit: 32'hAB00_0000};
    vecs[5] = '{pos: {4{9'd77}}, dmg: {4{8'd60}},
                dead: 4'b0000, pFront: 9'd0, pDmg: 8'hFF,
                expFront: 9'd77, expBase: 8'd240, expHit: 32'h0000_00FF};
    vecs[6] = '{pos: {9'd60, 9'd61, 9'd511, 9'd511}, dmg: {8'd128, 8'd128, 8'd200, 8'd200},
                dead: 4'b0011, pFront: 9'd33, pDmg: 8'h44,
                expFront: 9'd61, expBase: 8'd255, expHit: 32'h0044_0000};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_moveSCEN",   64'(moveSCEN),      64'd0);
    checkOutput("rst_damageSCEN", 64'(damageSCEN),    64'd0);
    checkOutput("rst_unitFront",  64'(unitFront),     64'd0);
    checkOutput("rst_damageTo",   64'(damageToEnemy), 64'd0);
    checkOutput("rst_canSpawn",   64'(canSpawn),      64'd0);
    checkOutput("rst_spawnType",  64'(spawnType),     64'd0);
    checkOutput("rst_enemyFront", 64'(enemyFront),    64'd0);
    checkOutput("rst_baseDamage", 64'(baseDamage),    64'd0);
    checkOutput("rst_roundCount", 64'(roundCount),    64'd0);

    // All slots dead: spawn at cycle 19, then again four rounds later.
    enemyDead = 4'b1111;
    enable    = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    lfsrModel = 8'hA5;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      lfsrModel = lfsrStep(lfsrModel);
      checkOutput($sformatf("spawn_c%0d", k), 64'(canSpawn),
                  ((k == 19) || (k == 99)) ? 64'd1 : 64'd0);
      if (k == 19)  checkOutput("spawnType", 64'(spawnType), 64'(lfsrModel[1:0]));
      if (k == 20)  checkOutput("round_after1", 64'(roundCount), 64'd1);
      if (k == 100) checkOutput("round_after5", 64'(roundCount), 64'd5);
    end

    // Enable low in WAIT holds the FSM; dropping it mid-round finishes the round.
    enable   = 1'b0;
    moveSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (moveSCEN) moveSeen++;
    end
    checkOutput("hold_noMove", 64'(moveSeen), 64'd0);
    checkOutput("hold_round",  64'(roundCount), 64'd5);
    enable = 1'b1;
    n = 0;
    while ((n < 40) && !moveSCEN) begin
      @(negedge clk);
      n++;
    end
    checkOutput("resume_moveDelay", 64'(n), 64'd16);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midDrop_damage", 64'(damageSCEN), 64'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midDrop_round", 64'(roundCount), 64'd6);
    moveSeen = 0;
    repeat (25) begin
      @(negedge clk);
      if (moveSCEN) moveSeen++;
    end
    checkOutput("midDrop_noMove", 64'(moveSeen), 64'd0);

    // Table-driven rounds, checked on each damage strobe.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      enable = 1'b1;
      waitForDamage(found);
      if (found) checkRound($sformatf("vec%0d", i));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
    end

    // Reset asserted in DAMAGE clears everything immediately.
    applyStimulus(vecs[0]);
    waitForDamage(found);
    if (found) checkRound("preReset");
    reset = 1'b1;
    #1;
    checkOutput("midRst_damageSCEN", 64'(damageSCEN),    64'd0);
    checkOutput("midRst_damageTo",   64'(damageToEnemy), 64'd0);
    checkOutput("midRst_roundCount", 64'(roundCount),    64'd0);
    checkOutput("midRst_enemyFront", 64'(enemyFront),    64'd0);
    checkOutput("midRst_baseDamage", 64'(baseDamage),    64'd0);
    checkOutput("midRst_unitFront",  64'(unitFront),     64'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while ((n < 40) && !moveSCEN) begin
      @(negedge clk);
      n++;
    end
    checkOutput("postRst_moveDelay", 64'(n), 64'd16);
    checkOutput("postRst_round",     64'(roundCount), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
